// File: rtl/pwm_output_stage_if.sv
// Command link between the float PID controller and the PWM output stage.
// The controller drives a float duty command with a one-cycle strobe and can observe busy.
interface pwm_output_stage_if;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;

    modport master (
        output result,
        output result_valid,
        input  busy
    );

    modport slave (
        input  result,
        input  result_valid,
        output busy
    );
endinterface

// File: rtl/pwm_output_stage.sv
// Float duty command -> saturated, double-buffered magnitude/direction -> edge-aligned PWM
// with dead-time inserted at the start of any period in which the bridge direction reverses.
module pwm_output_stage #(
    parameter int PERIOD      = 2000,
    parameter int DEAD_CYCLES = 50,
    parameter int CNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    pwm_output_stage_if.slave  cmd,
    output logic               o_pwm,
    output logic               o_dir,
    output logic [CNT_W-1:0]   o_duty_active,
    output logic               o_saturated
);

    localparam logic [CNT_W-1:0] LP_PERIOD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] LP_DEAD   = CNT_W'(DEAD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_SHIFT,
        S_SAT
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [31:0]        r_result;
    logic [31:0]        r_holdData;
    logic               r_holdFull;
    logic               r_sign;
    logic [7:0]         r_exp;
    logic [22:0]        r_frac;
    logic [CNT_W-1:0]   r_mag;
    logic               r_specSat;
    logic [CNT_W-1:0]   r_dutyPending;
    logic               r_signPending;
    logic [CNT_W-1:0]   r_dutyActive;
    logic               r_dir;
    logic               r_deadTime;
    logic               r_saturated;
    logic               r_pwm;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_start;
    logic               w_busy;
    logic               w_doUnpack;
    logic               w_doShift;
    logic               w_doSat;
    logic [23:0]        w_mant;
    logic [CNT_W-1:0]   w_shiftMag;
    logic               w_shiftSat;
    logic [CNT_W-1:0]   w_satMag;
    logic               w_satFlag;
    logic [CNT_W-1:0]   w_pendDutyNext;
    logic               w_pendSignNext;
    logic               w_wrap;

    // A pending hold entry starts a new conversion as soon as the FSM is back in IDLE.
    assign w_start = (r_state == S_IDLE) && (cmd.result_valid || r_holdFull);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_stateNext = S_UNPACK;
            S_UNPACK: w_stateNext = S_SHIFT;
            S_SHIFT:  w_stateNext = S_SAT;
            S_SAT:    w_stateNext = S_IDLE;
            default:  w_stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_doUnpack = (r_state == S_UNPACK);
        w_doShift  = (r_state == S_SHIFT);
        w_doSat    = (r_state == S_SAT);
    end

    assign cmd.busy = w_busy;

    // Float magnitude decode; exponents at or above 127+CNT_W cannot fit the counter and clip.
    always_comb begin
        w_mant     = {1'b1, r_frac};
        w_shiftMag = '0;
        w_shiftSat = 1'b0;
        if (r_exp < 8'd127) begin
            w_shiftMag = '0;
        end else if (r_exp == 8'hFF) begin
            if (r_frac == 23'd0) begin
                w_shiftMag = LP_PERIOD;
                w_shiftSat = 1'b1;
            end
        end else if ({24'd0, r_exp} >= 32'(127 + CNT_W)) begin
            w_shiftMag = LP_PERIOD;
            w_shiftSat = 1'b1;
        end else if (r_exp > 8'd150) begin
            w_shiftMag = CNT_W'(64'(w_mant) << (r_exp - 8'd150));
        end else begin
            w_shiftMag = CNT_W'(64'(w_mant) >> (8'd150 - r_exp));
        end
    end

    always_comb begin
        w_satMag       = (r_mag > LP_PERIOD) ? LP_PERIOD : r_mag;
        w_satFlag      = r_specSat || (r_mag > LP_PERIOD);
        w_pendDutyNext = r_dutyPending;
        w_pendSignNext = r_signPending;
        if (w_doSat) begin
            w_pendDutyNext = w_satMag;
            if (w_satMag != '0) begin
                w_pendSignNext = r_sign;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_result    <= '0;
            r_holdData  <= '0;
            r_holdFull  <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_frac      <= '0;
            r_mag       <= '0;
            r_specSat   <= 1'b0;
            r_saturated <= 1'b0;
        end else begin
            if (w_start) begin
                r_result <= cmd.result_valid ? cmd.result : r_holdData;
            end
            if (w_busy && cmd.result_valid) begin
                r_holdData <= cmd.result;
                r_holdFull <= 1'b1;
            end else if (w_start) begin
                r_holdFull <= 1'b0;
            end
            if (w_doUnpack) begin
                r_sign <= r_result[31];
                r_exp  <= r_result[30:23];
                r_frac <= r_result[22:0];
            end
            if (w_doShift) begin
                r_mag     <= w_shiftMag;
                r_specSat <= w_shiftSat;
            end
            if (w_doSat) begin
                r_saturated <= w_satFlag;
            end
        end
    end

    assign w_wrap = (r_cnt == LP_LAST);

    // The wrap loads the next-cycle pending values, so a write landing on the wrap cycle is not lost.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_dutyPending <= '0;
            r_signPending <= 1'b0;
            r_dutyActive  <= '0;
            r_dir         <= 1'b0;
            r_deadTime    <= 1'b0;
            r_pwm         <= 1'b0;
        end else begin
            r_cnt         <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_dutyPending <= w_pendDutyNext;
            r_signPending <= w_pendSignNext;
            if (w_wrap) begin
                r_dutyActive <= w_pendDutyNext;
                r_dir        <= w_pendSignNext;
                r_deadTime   <= (w_pendSignNext != r_dir);
            end
            r_pwm <= (r_cnt < r_dutyActive) && !(r_deadTime && (r_cnt < LP_DEAD));
        end
    end

    assign o_pwm         = r_pwm;
    assign o_dir         = r_dir;
    assign o_duty_active = r_dutyActive;
    assign o_saturated   = r_saturated;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage: table-driven float commands with a wrap-time
// scoreboard, per-period PWM shape checks, and hand-written timing corner sequences.
module tb_pwm_output_stage;

    localparam int PERIOD = 2000;
    localparam int DEAD   = 50;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [31:0] data;
        int          duty;
        logic        dirV;
        logic        sat;
    } vec_t;

    typedef struct {
        int   duty;
        logic dirV;
        logic sat;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             pwm;
    logic             dir;
    logic             saturated;
    logic [CNT_W-1:0] dutyActive;

    exp_t sbQueue[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;
    int   tbCnt = 0;
    logic modelDir = 1'b0;
    int   lastDuty = 0;
    bit   lastDead = 1'b0;

    pwm_output_stage_if cmdIf ();

    pwm_output_stage #(
        .PERIOD      (PERIOD),
        .DEAD_CYCLES (DEAD),
        .CNT_W       (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd           (cmdIf),
        .o_pwm         (pwm),
        .o_dir         (dir),
        .o_duty_active (dutyActive),
        .o_saturated   (saturated)
    );

    always #5 clock = ~clock;

    // Reference period counter: the bench's own notion of where the PWM period is.
    always @(posedge clock) begin
        if (!reset) tbCnt <= 0;
        else        tbCnt <= (tbCnt == PERIOD - 1) ? 0 : tbCnt + 1;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic waitCnt(input int target);
        int guard = 0;
        while (tbCnt != target && guard < 3 * PERIOD) begin
            @(negedge clock);
            guard++;
        end
        if (tbCnt != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitCnt: counter %0d never reached %0d", tbCnt, target);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input int expDuty, input logic expDir,
                                 input logic expSat, input bit checkBusy);
        cmdIf.result       = data;
        cmdIf.result_valid = 1'b1;
        @(posedge clock);
        #1 cmdIf.result_valid = 1'b0;
        sbQueue.push_back('{expDuty, expDir, expSat});
        if (checkBusy) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                check("busy during conversion", int'(cmdIf.busy), 1);
            end
            @(negedge clock);
            check("busy after conversion", int'(cmdIf.busy), 0);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: wrap reached with no expected entry");
            return;
        end
        e = sbQueue.pop_front();
        check("duty_active at wrap", int'(dutyActive), e.duty);
        check("dir at wrap", int'(dir), int'(e.dirV));
        check("saturated at wrap", int'(saturated), int'(e.sat));
        lastDead = (e.dirV != modelDir);
        modelDir = e.dirV;
        lastDuty = e.duty;
    endtask

    // pwm lags the counter by one cycle, so the sample taken at count k describes count k-1.
    task automatic measurePeriod(input int duty, input bit dead);
        int highs = 0;
        int first = -1;
        int start;
        int expHighs;
        for (int i = 0; i < PERIOD; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (pwm === 1'b1) begin
                highs++;
                if (first < 0) first = i;
            end
        end
        start    = dead ? DEAD : 0;
        expHighs = (duty > start) ? duty - start : 0;
        check("pwm high cycles", highs, expHighs);
        check("pwm first high count", first, (expHighs > 0) ? start : -1);
    endtask

    initial begin
        vecs = '{
            '{32'h43FA0000,  500, 1'b0, 1'b0},
            '{32'hC37AC000,  250, 1'b1, 1'b0},
            '{32'h49742400, 2000, 1'b0, 1'b1},
            '{32'h7FC00000,    0, 1'b0, 1'b0},
            '{32'hC2C80000,  100, 1'b1, 1'b0},
            '{32'h3F000000,    0, 1'b1, 1'b0},
            '{32'hBF800000,    1, 1'b1, 1'b0},
            '{32'h7F800000, 2000, 1'b0, 1'b1},
            '{32'h44FA0000, 2000, 1'b0, 1'b0},
            '{32'h44FA2000, 2000, 1'b0, 1'b1},
            '{32'h80000000,    0, 1'b0, 1'b0}
        };

        reset              = 1'b0;
        cmdIf.result       = '0;
        cmdIf.result_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset pwm", int'(pwm), 0);
        check("reset dir", int'(dir), 0);
        check("reset duty_active", int'(dutyActive), 0);
        check("reset busy", int'(cmdIf.busy), 0);
        check("reset saturated", int'(saturated), 0);
        reset = 1'b1;
        measurePeriod(0, 1'b0);

        for (int v = 0; v < 11; v++) begin
            waitCnt(10);
            applyStimulus(vecs[v].data, vecs[v].duty, vecs[v].dirV, vecs[v].sat, 1'b1);
            waitCnt(0);
            checkOutput();
            measurePeriod(lastDuty, lastDead);
        end

        // Back-to-back strobes: the first conversion lands exactly on the wrap cycle.
        waitCnt(PERIOD - 4);
        cmdIf.result       = 32'h42C80000;
        cmdIf.result_valid = 1'b1;
        @(posedge clock);
        #1 cmdIf.result    = 32'h43480000;
        @(posedge clock);
        #1 cmdIf.result    = 32'h43960000;
        @(posedge clock);
        #1 cmdIf.result_valid = 1'b0;
        sbQueue.push_back('{100, 1'b0, 1'b0});
        sbQueue.push_back('{300, 1'b0, 1'b0});
        @(negedge clock);
        check("b2b busy in SAT", int'(cmdIf.busy), 1);
        @(negedge clock);
        check("b2b busy idle gap", int'(cmdIf.busy), 0);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("b2b busy second conversion", int'(cmdIf.busy), 1);
        end
        @(negedge clock);
        check("b2b busy after second", int'(cmdIf.busy), 0);
        waitCnt(0);
        checkOutput();
        measurePeriod(lastDuty, lastDead);

        // Pending write on the wrap cycle is applied now; one cycle later waits a full period.
        waitCnt(PERIOD - 4);
        applyStimulus(32'h44160000, 600, 1'b0, 1'b0, 1'b0);
        waitCnt(0);
        checkOutput();
        waitCnt(PERIOD - 3);
        cmdIf.result       = 32'h442F0000;
        cmdIf.result_valid = 1'b1;
        @(posedge clock);
        #1 cmdIf.result_valid = 1'b0;
        waitCnt(0);
        check("late write not applied", int'(dutyActive), 600);
        sbQueue.push_back('{700, 1'b0, 1'b0});
        waitCnt(1);
        waitCnt(0);
        checkOutput();

        // Reset while the FSM is in SHIFT with a command waiting in the hold register.
        waitCnt(10);
        cmdIf.result       = 32'hC4480000;
        cmdIf.result_valid = 1'b1;
        @(posedge clock);
        #1 cmdIf.result    = 32'h42C80000;
        @(posedge clock);
        #1 cmdIf.result_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mid reset busy", int'(cmdIf.busy), 0);
        check("mid reset duty_active", int'(dutyActive), 0);
        check("mid reset dir", int'(dir), 0);
        check("mid reset pwm", int'(pwm), 0);
        check("mid reset saturated", int'(saturated), 0);
        reset    = 1'b1;
        modelDir = 1'b0;
        begin
            int busySeen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clock);
                if (cmdIf.busy === 1'b1) busySeen++;
            end
            check("hold discarded by reset", busySeen, 0);
        end
        waitCnt(0);
        check("duty after reset wrap", int'(dutyActive), 0);
        check("dir after reset wrap", int'(dir), 0);
        check("scoreboard drained", sbQueue.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
